// File: rtl/lsu_pkg.sv
// Shared types for the load/store front-end: funct3 mask encoding, store-buffer entry, alignment check.
// Combinational helpers only; no state.
package lsu_pkg;

    typedef enum logic [2:0] {
        MASK_B  = 3'b000,
        MASK_H  = 3'b001,
        MASK_W  = 3'b010,
        MASK_BU = 3'b100,
        MASK_HU = 3'b101
    } mask_e;

    // Stores only use B/H/W, so the low two funct3 bits fully describe the access width.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
    } sb_entry_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] mask);
        logic mis;
        mis = 1'b0;
        case (mask)
            MASK_H, MASK_HU: mis = addr_lo[0];
            MASK_W:          mis = |addr_lo;
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_sb_fifo.sv
// Store-buffer storage: circular FIFO of sb_entry_t plus word-address hit detection over occupied entries.
// Push/pop take effect at posedge; hit/head/empty/full are combinational. Caller must not push when full.
module lsu_sb_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  sb_entry_t   i_push_dat,
    input  logic        i_pop,
    output sb_entry_t   o_head_dat,
    input  logic [29:0] i_lookup_word,
    output logic        o_hit,
    output logic        o_empty,
    output logic        o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   w_match;

    // An entry is live when its distance from head (mod DEPTH) is below the occupancy count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        logic [PTR_W-1:0] w_off;
        assign w_off       = PTR_W'(gi) - r_head;
        assign w_match[gi] = ({1'b0, w_off} < r_count) && (r_mem[gi].addr[31:2] == i_lookup_word);
    end

    assign o_hit      = |w_match;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_head_dat = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lsu_store_buffer.sv
// MEM-stage load/store front-end: loads go straight to dmem, stores queue and drain one per cycle.
// Loads return in the accept cycle; loads hitting a queued word, full-buffer stores and flush stall req_ready.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mask,
    output logic [31:0] ld_data,
    output logic        misaligned,
    input  logic        flush,
    output logic        sb_empty,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [2:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    sb_entry_t w_push_dat;
    sb_entry_t w_head_dat;
    logic      w_hit;
    logic      w_empty;
    logic      w_full;
    logic      w_mis;
    logic      w_hazard;
    logic      w_accept;
    logic      w_ld_issue;
    logic      w_st_push;
    logic      w_drain;
    logic      r_misaligned;

    assign w_mis    = is_misaligned(req_addr[1:0], req_mask);
    assign w_hazard = req_valid && !req_wr && w_hit;

    assign req_ready  = !flush && (req_wr ? !w_full : !w_hazard);
    assign w_accept   = req_valid && req_ready;
    assign w_ld_issue = w_accept && !req_wr && !w_mis;
    assign w_st_push  = w_accept && req_wr && !w_mis;
    // A load owns the single port; the head store waits one cycle behind it.
    assign w_drain    = !w_ld_issue && !w_empty;

    assign w_push_dat = '{addr: req_addr, wdata: req_wdata, mask: req_mask[1:0]};
    assign sb_empty   = w_empty;
    assign misaligned = r_misaligned;

    lsu_sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_st_push),
        .i_push_dat    (w_push_dat),
        .i_pop         (w_drain),
        .o_head_dat    (w_head_dat),
        .i_lookup_word (req_addr[31:2]),
        .o_hit         (w_hit),
        .o_empty       (w_empty),
        .o_full        (w_full)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_mask  = '0;
        ld_data   = '0;
        if (w_ld_issue) begin
            mem_rd   = 1'b1;
            mem_addr = req_addr;
            mem_mask = req_mask;
            ld_data  = mem_rdata;
        end else if (w_drain) begin
            mem_wr    = 1'b1;
            mem_addr  = w_head_dat.addr;
            mem_wdata = w_head_dat.wdata;
            mem_mask  = {1'b0, w_head_dat.mask};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_mis;
        end
    end

endmodule
